// File: rtl/uart_pkg.sv
// Shared UART types and framing constants; frame layout depends on UART_XMIT_PARITY_EN.
package uart_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XMIT = 1'b1
   } tx_state_t;

`ifdef UART_XMIT_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   localparam int UART_DEF_BAUD_DIV = 2604;
   localparam int BAUD_CNT_W        = 12;
   localparam int BIT_CNT_W         = 4;

   // Frame image in shift order: bit 0 is the start bit, MSB is the stop bit.
   function automatic logic [FRAME_BITS-1:0] frame_load(input logic [7:0] data);
`ifdef UART_XMIT_PARITY_EN
      return {1'b1, ^data, data, 1'b0};
`else
      return {1'b1, data, 1'b0};
`endif
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate divider: one-cycle tick every BAUD_DIV enabled cycles, held at zero when disabled.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = UART_DEF_BAUD_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam logic [BAUD_CNT_W-1:0] LAST = BAUD_CNT_W'(BAUD_DIV - 1);

   logic [BAUD_CNT_W-1:0] baud_cnt;

   assign tick = en && (baud_cnt == LAST);

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_cnt <= '0;
      end else if (clr || !en || tick) begin
         baud_cnt <= '0;
      end else begin
         baud_cnt <= baud_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/uart_xmit.sv
// UART transmitter, LSB first, idle-high line; even parity appended when UART_XMIT_PARITY_EN is defined.
module uart_xmit
   import uart_pkg::*;
#(
   parameter int BAUD_DIV = UART_DEF_BAUD_DIV
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   input  logic       clr_tx_done,
   output logic       TX,
   output logic       tx_busy,
   output logic       tx_done
);

   tx_state_t             state;
   logic [FRAME_BITS-1:0] shifter;
   logic [BIT_CNT_W-1:0]  bit_cnt;
   logic                  tick;
   logic                  accept;
   logic                  last_shift;

   assign accept     = trmt && (state == IDLE);
   assign last_shift = tick && (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1));

   uart_baud_tick #(
      .BAUD_DIV (BAUD_DIV)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .en   (state == XMIT),
      .clr  (accept),
      .tick (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         shifter <= '1;
         bit_cnt <= '0;
         TX      <= 1'b1;
         tx_busy <= 1'b0;
         tx_done <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  shifter <= frame_load(tx_data);
                  bit_cnt <= '0;
                  TX      <= 1'b0;
                  tx_busy <= 1'b1;
                  tx_done <= 1'b0;
                  state   <= XMIT;
               end else if (clr_tx_done) begin
                  tx_done <= 1'b0;
               end
            end
            XMIT: begin
               if (clr_tx_done) tx_done <= 1'b0;
               if (tick) begin
                  // TX tracks the bit that becomes shifter[0] after this shift.
                  shifter <= {1'b1, shifter[FRAME_BITS-1:1]};
                  TX      <= shifter[1];
                  bit_cnt <= bit_cnt + 1'b1;
                  if (last_shift) begin
                     tx_busy <= 1'b0;
                     tx_done <= 1'b1;
                     state   <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_xmit.sv
// Self-checking bench for uart_xmit at BAUD_DIV=16 against a bit-per-frame reference model.
module tb_uart_xmit;

   localparam int BD = 16;
`ifdef UART_XMIT_PARITY_EN
   localparam int FB = 11;
`else
   localparam int FB = 10;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       trmt;
   logic [7:0] tx_data;
   logic       clr_tx_done;
   logic       TX;
   logic       tx_busy;
   logic       tx_done;

   int checks = 0;
   int errors = 0;

   uart_xmit #(.BAUD_DIV(BD)) dut (
      .clk         (clk),
      .rst         (rst),
      .trmt        (trmt),
      .tx_data     (tx_data),
      .clr_tx_done (clr_tx_done),
      .TX          (TX),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done)
   );

   always #5 clk = ~clk;

   // Reference: line level for bit slot idx of a frame carrying d.
   function automatic logic frame_bit(input logic [7:0] d, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
`ifdef UART_XMIT_PARITY_EN
      if (idx == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Entered just after a negedge; the following posedge accepts the frame.
   task automatic send_frame(input logic [7:0] d, input int intrude_at,
                             input bit clr_at_end, input bit trmt_at_end);
      tx_data = d;
      trmt    = 1'b1;
      for (int k = 0; k < FB*BD; k++) begin
         @(negedge clk);
         if (k == 0) begin
            trmt    = 1'b0;
            tx_data = 8'($urandom);
            check("accept_busy", 32'(tx_busy), 32'd1);
            check("accept_done_cleared", 32'(tx_done), 32'd0);
         end
         check($sformatf("tx_bit d=%02h k=%0d", d, k), 32'(TX), 32'(frame_bit(d, k / BD)));
         if (k == FB*BD-1) begin
            check("busy_before_end", 32'(tx_busy), 32'd1);
            check("done_before_end", 32'(tx_done), 32'd0);
         end
         trmt = (k == intrude_at) || (trmt_at_end && (k == FB*BD-1));
         if (k == intrude_at) tx_data = 8'h00;
         clr_tx_done = clr_at_end && (k == FB*BD-1);
      end
      @(negedge clk);
      trmt = 1'b0;
      check("end_busy", 32'(tx_busy), 32'd0);
      check("end_done", 32'(tx_done), 32'd1);
      check("end_tx_high", 32'(TX), 32'd1);
      if (clr_at_end) begin
         @(negedge clk);
         check("clr_next_cycle", 32'(tx_done), 32'd0);
      end
      clr_tx_done = 1'b0;
      if (trmt_at_end) begin
         @(negedge clk);
         check("end_trmt_ignored_busy", 32'(tx_busy), 32'd0);
         check("end_trmt_ignored_tx", 32'(TX), 32'd1);
      end
   endtask

   initial begin
      rst         = 1'b1;
      trmt        = 1'b0;
      tx_data     = 8'h00;
      clr_tx_done = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_tx", 32'(TX), 32'd1);
      check("reset_busy", 32'(tx_busy), 32'd0);
      check("reset_done", 32'(tx_done), 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("idle_tx", 32'(TX), 32'd1);
      check("idle_busy", 32'(tx_busy), 32'd0);

      // Basic frame, then a frame with an intruding trmt mid-flight.
      send_frame(8'hA5, -1, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      send_frame(8'hA5, 40, 1'b0, 1'b0);

      // Back-to-back frames; the last one also probes trmt on the end cycle.
      send_frame(8'h55, -1, 1'b0, 1'b0);
      send_frame(8'hFF, -1, 1'b0, 1'b1);

      // Reset in the middle of bit 4.
      tx_data = 8'($urandom);
      trmt    = 1'b1;
      @(negedge clk);
      trmt = 1'b0;
      repeat (4*BD + 3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midreset_tx", 32'(TX), 32'd1);
      check("midreset_busy", 32'(tx_busy), 32'd0);
      check("midreset_done", 32'(tx_done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (FB*BD) @(negedge clk);
      check("after_reset_no_done", 32'(tx_done), 32'd0);
      check("after_reset_tx", 32'(TX), 32'd1);
      send_frame(8'h3C, -1, 1'b0, 1'b0);

      // clr_tx_done colliding with the set cycle.
      send_frame(8'($urandom), -1, 1'b1, 1'b0);

      // Randomised frames with random idle gaps.
      for (int i = 0; i < 8; i++) begin
         logic [7:0] d;
         d = 8'($urandom);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send_frame(d, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, FB*BD-2)) : -1,
                    1'($urandom_range(0, 1)), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
